// File: rtl/la_prot_pkg.sv
// Shared definitions for the logic-analyser protocol triggers (UART, SPI):
// frame FSM states and the minimum usable bit period.
package la_prot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } prot_state_e;

  localparam int unsigned MIN_BAUD = 4;

  // Bit periods below MIN_BAUD are clamped so the half-period count stays >= 2.
  function automatic logic [15:0] eff_period(input logic [15:0] baud);
    return (baud < 16'(MIN_BAUD)) ? 16'(MIN_BAUD) : baud;
  endfunction

endpackage

// File: rtl/prot_sync.sv
// Multi-flop synchronizer for an asynchronous serial line plus falling-edge
// detection on the synchronized value. Flops reset to the idle-high level.
module prot_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_o;

endmodule

// File: rtl/uart_prot_trig.sv
// UART byte-match trigger: decodes 8N1 frames on RX and pulses UARTtrig for one
// clk when the masked byte matches. Define UART_PROT_STOP_CHECK_EN to suppress on framing errors.
module uart_prot_trig
  import la_prot_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [15:0] baud_cnt,
  input  logic [7:0]  match,
  input  logic [7:0]  mask,
  output logic        UARTtrig
);

  logic        rx_sync;
  logic        rx_fall;
  logic        match_hit;
  logic        stop_ok;

  prot_state_e state_q;
  logic [15:0] period_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  match_q;
  logic [7:0]  mask_q;
  logic        trig_q;

  prot_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (RX),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

  assign match_hit = (((shift_q ^ match_q) & ~mask_q) == 8'h00);

`ifdef UART_PROT_STOP_CHECK_EN
  assign stop_ok = rx_sync;
`else
  assign stop_ok = 1'b1;
`endif

  // cnt_q counts down to the next sample point; configuration is frozen at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      match_q  <= '0;
      mask_q   <= '0;
      trig_q   <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            period_q <= eff_period(baud_cnt);
            match_q  <= match;
            mask_q   <= mask;
            cnt_q    <= (eff_period(baud_cnt) >> 1) - 16'd1;
            bit_q    <= '0;
            state_q  <= START;
          end
        end
        START: begin
          if (cnt_q == 16'd0) begin
            if (!rx_sync) begin
              cnt_q   <= period_q - 16'd1;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == 16'd0) begin
            shift_q <= {rx_sync, shift_q[7:1]};
            cnt_q   <= period_q - 16'd1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == 16'd0) begin
            trig_q  <= match_hit & stop_ok;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign UARTtrig = trig_q;

endmodule

// File: tb/tb_uart_prot_trig.sv
// Self-checking bench for uart_prot_trig: directed scenarios plus randomized
// frames checked against a bit-level reference model of the match rule.
module tb_uart_prot_trig;

  localparam int SYNC_STAGES = 2;
  // RX change to first visible effect: synchronizer stages plus the edge register.
  localparam int LAT = SYNC_STAGES + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] baud_cnt = 16'd0;
  logic [7:0]  match = 8'h00;
  logic [7:0]  mask = 8'h00;
  logic        UARTtrig;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cyc[$];
  int wide_cnt = 0;
  logic trig_prev = 1'b0;

  uart_prot_trig #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .baud_cnt (baud_cnt),
    .match    (match),
    .mask     (mask),
    .UARTtrig (UARTtrig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records the cycle of every rising pulse, counts over-long pulses.
  always @(negedge clk) begin
    if (UARTtrig === 1'b1) begin
      if (trig_prev) wide_cnt = wide_cnt + 1;
      else pulse_cyc.push_back(cyc);
    end
    trig_prev = (UARTtrig === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame fires when every cared-for bit agrees.
  function automatic bit model_hit(input logic [7:0] d, input logic [7:0] m,
                                   input logic [7:0] k, input logic stop);
    bit hit;
    hit = 1'b1;
    for (int i = 0; i < 8; i++)
      if (!k[i] && (d[i] != m[i])) hit = 1'b0;
`ifdef UART_PROT_STOP_CHECK_EN
    if (!stop) hit = 1'b0;
`else
    if (stop) hit = hit;
`endif
    return hit;
  endfunction

  // Nominal pulse delay from the start-bit edge: centre of the stop bit (9.5 bits) plus LAT.
  function automatic int exp_delay(input int p);
    return (19 * p) / 2 + LAT;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p,
                            input bit scramble, output int start_cyc);
    start_cyc = cyc;
    RX = 1'b0;
    tick(p);
    if (scramble) begin
      baud_cnt = 16'($urandom);
      match    = 8'($urandom);
      mask     = 8'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      tick(p);
    end
    RX = stop;
    tick(p);
    RX = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input int p,
                           input bit scramble, input int gap,
                           output int npulse, output int delta);
    int n0;
    int s;
    n0 = pulse_cyc.size();
    send_frame(d, stop, p, scramble, s);
    tick(gap);
    npulse = pulse_cyc.size() - n0;
    delta  = (npulse > 0) ? pulse_cyc[n0] - s : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RX = i[0];
      tick(2);
      checks++;
      if (UARTtrig !== 1'b0) begin
        errors++;
        $display("FAIL reset_out: got %b expected 0", UARTtrig);
      end
    end
    RX = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(6);
    checks++;
    if (UARTtrig !== 1'b0 || pulse_cyc.size() != 0) begin
      errors++;
      $display("FAIL reset_release: got trig=%b pulses=%0d expected 0/0", UARTtrig, pulse_cyc.size());
    end
    $display("test_reset done");
  endtask

  task automatic test_match;
    int n, dl;
    baud_cnt = 16'd868; match = 8'h96; mask = 8'h00;
    run_frame(8'h96, 1'b1, 868, 1'b0, 872, n, dl);
    checks++;
    if (n != 1) begin errors++; $display("FAIL match_exact_count: got %0d expected 1", n); end
    checks++;
    if (dl < exp_delay(868) - 2 || dl > exp_delay(868) + 2) begin
      errors++; $display("FAIL match_exact_time: got %0d expected %0d+-2", dl, exp_delay(868));
    end
    $display("frame 96 match=96 mask=00 pulses=%0d delay=%0d", n, dl);
    match = 8'h97;
    run_frame(8'h96, 1'b1, 868, 1'b0, 872, n, dl);
    checks++;
    if (n != 0) begin errors++; $display("FAIL mismatch_count: got %0d expected 0", n); end
    $display("frame 96 match=97 mask=00 pulses=%0d", n);
    match = 8'h90; mask = 8'h0F;
    run_frame(8'h96, 1'b1, 868, 1'b0, 872, n, dl);
    checks++;
    if (n != 1) begin errors++; $display("FAIL masked_count: got %0d expected 1", n); end
    $display("frame 96 match=90 mask=0F pulses=%0d", n);
  endtask

  task automatic test_glitch;
    int n0, n, dl;
    baud_cnt = 16'd868; match = 8'h96; mask = 8'h00;
    n0 = pulse_cyc.size();
    RX = 1'b0;
    tick(100);
    RX = 1'b1;
    tick(868);
    checks++;
    if (pulse_cyc.size() != n0) begin
      errors++; $display("FAIL glitch_count: got %0d expected 0", pulse_cyc.size() - n0);
    end
    run_frame(8'h96, 1'b1, 868, 1'b0, 872, n, dl);
    checks++;
    if (n != 1 || dl < exp_delay(868) - 2 || dl > exp_delay(868) + 2) begin
      errors++; $display("FAIL after_glitch: got n=%0d delay=%0d expected n=1 delay=%0d", n, dl, exp_delay(868));
    end
    $display("glitch then frame 96 pulses=%0d", n);
  endtask

  task automatic test_stop_bit;
    int n, dl, e;
    baud_cnt = 16'd100; match = 8'h96; mask = 8'h00;
    e = model_hit(8'h96, 8'h96, 8'h00, 1'b0) ? 1 : 0;
    run_frame(8'h96, 1'b0, 100, 1'b0, 104, n, dl);
    checks++;
    if (n != e) begin errors++; $display("FAIL stop_zero: got %0d expected %0d", n, e); end
    $display("frame 96 stop=0 pulses=%0d expected=%0d", n, e);
  endtask

  task automatic test_back_to_back;
    int n0, s1, s2, n, dl;
    baud_cnt = 16'd8; match = 8'h96; mask = 8'h00;
    n0 = pulse_cyc.size();
    send_frame(8'h96, 1'b1, 8, 1'b0, s1);
    send_frame(8'h96, 1'b1, 8, 1'b0, s2);
    tick(12);
    checks++;
    if (pulse_cyc.size() - n0 != 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", pulse_cyc.size() - n0);
    end else begin
      checks++;
      if (pulse_cyc[n0+1] - pulse_cyc[n0] != 80) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 80", pulse_cyc[n0+1] - pulse_cyc[n0]);
      end
    end
    $display("back-to-back baud=8 pulses=%0d", pulse_cyc.size() - n0);
    baud_cnt = 16'd2;
    run_frame(8'h96, 1'b1, 4, 1'b0, 8, n, dl);
    checks++;
    if (n != 1 || dl < exp_delay(4) - 2 || dl > exp_delay(4) + 2) begin
      errors++; $display("FAIL min_baud: got n=%0d delay=%0d expected n=1 delay=%0d", n, dl, exp_delay(4));
    end
    $display("baud=2 frame 96 pulses=%0d delay=%0d", n, dl);
  endtask

  task automatic test_reset_midframe;
    int n0, n, dl;
    logic [9:0] bits;
    baud_cnt = 16'd868; match = 8'h96; mask = 8'h00;
    bits = {1'b1, 8'h96, 1'b0};
    n0 = pulse_cyc.size();
    for (int i = 0; i < 5; i++) begin RX = bits[i]; tick(868); end
    RX = bits[5];
    tick(434);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (UARTtrig !== 1'b0) begin errors++; $display("FAIL reset_mid_out: got %b expected 0", UARTtrig); end
    tick(9);
    rst_n = 1'b1;
    tick(424);
    for (int i = 6; i < 10; i++) begin RX = bits[i]; tick(868); end
    RX = 1'b1;
    tick(868 * 6);
    checks++;
    if (pulse_cyc.size() != n0) begin
      errors++; $display("FAIL reset_abort: got %0d expected 0", pulse_cyc.size() - n0);
    end
    run_frame(8'h96, 1'b1, 868, 1'b0, 872, n, dl);
    checks++;
    if (n != 1) begin errors++; $display("FAIL after_reset: got %0d expected 1", n); end
    $display("reset mid-frame then frame 96 pulses=%0d", n);
  endtask

  task automatic test_random;
    int n, dl, e, p, praw;
    logic [7:0] d, m, k;
    logic stop;
    bit scr;
    for (int it = 0; it < 24; it++) begin
      praw = $urandom_range(0, 40);
      p = (praw < 4) ? 4 : praw;
      d = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      m = ($urandom_range(0, 1) == 1) ? (d ^ (8'($urandom) & k)) : 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      scr = ($urandom_range(0, 1) == 1);
      baud_cnt = 16'(praw); match = m; mask = k;
      e = model_hit(d, m, k, stop) ? 1 : 0;
      run_frame(d, stop, p, scr, p + 4, n, dl);
      checks++;
      if (n != e) begin
        errors++; $display("FAIL rand_count: it=%0d got %0d expected %0d", it, n, e);
      end else if (e == 1) begin
        checks++;
        if (dl < exp_delay(p) - 2 || dl > exp_delay(p) + 2) begin
          errors++; $display("FAIL rand_time: it=%0d got %0d expected %0d+-2", it, dl, exp_delay(p));
        end
      end
      $display("rand it=%0d baud=%0d data=%h match=%h mask=%h stop=%b scr=%0d pulses=%0d exp=%0d",
               it, praw, d, m, k, stop, scr, n, e);
    end
  endtask

  task automatic test_pulse_width;
    checks++;
    if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_glitch();
    test_stop_bit();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_prot_trig.md
UART_PROT_TRIG -- requirements
Module: uart_prot_trig

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of RX synchronizer flops (legal range 2..4).
REQ-002 SHALL have port clk, input, 1 bit: 100 MHz system clock. All logic uses the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port RX, input, 1 bit: asynchronous serial line (muxed channel CH1), idle high.
REQ-005 SHALL have port baud_cnt, input, 16 bits: clk cycles per bit.
REQ-006 SHALL have port match, input, 8 bits: byte to compare against.
REQ-007 SHALL have port mask, input, 8 bits: a 1 bit marks that bit as don't-care.
REQ-008 SHALL have port UARTtrig, output, 1 bit: one-cycle pulse on a matching frame, feeding trigger logic.

Function
REQ-009 SHALL pass RX through SYNC_STAGES flops and detect a falling edge on the synchronized value.
REQ-010 SHALL implement a state machine with the states IDLE, START, DATA and STOP.
REQ-011 IDLE -> START on a synchronized falling edge; baud_cnt, match and mask are latched at this transition and held for the whole frame.
REQ-012 Effective bit period SHALL be max(latched baud_cnt, 4).
REQ-013 START: sample the line at half a bit period (period>>1) after the edge.
- Low: go to DATA.
- High: treat as a false start and return to IDLE with no pulse.
REQ-014 DATA: sample one full period after each previous sample; shift the 8 bits LSB-first; after the 8th sample go to STOP.
REQ-015 STOP: sample one full period after the 8th data bit; then return to IDLE.
REQ-016 Match condition SHALL be ((rx_byte ^ match) & ~mask) == 8'h00.
REQ-017 UARTtrig SHALL assert for exactly one clk, the cycle after the stop-bit sample, when the match condition holds (subject to REQ-022/023).
REQ-018 A new falling edge SHALL be accepted in the cycle immediately after the return to IDLE, so back-to-back frames are supported.
REQ-019 Changes to baud_cnt, match or mask during a frame SHALL NOT affect that frame.

Reset
REQ-020 While rst_n is low:
- state = IDLE
- synchronizer flops = 1
- counters, shift register and latched configuration = 0
- UARTtrig = 0
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, a frame SHALL be accepted only after a new falling edge.

Configuration
REQ-022 With UART_PROT_STOP_CHECK_EN defined: a stop-bit sample of 0 is a framing error, and UARTtrig SHALL NOT pulse even when the data matches.
REQ-023 Without UART_PROT_STOP_CHECK_EN: the stop-bit value SHALL be ignored.

Structure
REQ-024 The state enum (IDLE, START, DATA, STOP) and the constant MIN_BAUD = 4 SHALL live in shared package la_prot_pkg, which is reused by the SPI protocol trigger.
REQ-025 Synchronization and falling-edge detection SHALL be sub-module prot_sync (parameter SYNC_STAGES), instantiated once.
REQ-026 Target size: 120-400 lines of RTL.

Verification
REQ-027 baud_cnt=868, match=8'h96, mask=8'h00, frame 8'h96 sent on RX -> exactly one UARTtrig pulse, 1 clk wide, within 2 clk of the stop-bit centre.
REQ-028 Same setup with match=8'h97, mask=8'h00 -> no pulse. With match=8'h90, mask=8'h0F -> one pulse.
REQ-029 RX low-glitch of 100 clk with baud_cnt=868 -> no pulse; FSM back in IDLE before the next edge. A following valid 8'h96 frame -> one pulse.
REQ-030 Frame 8'h96 with stop bit driven 0 -> no pulse with UART_PROT_STOP_CHECK_EN defined, one pulse without it.
REQ-031 Two back-to-back 8'h96 frames with 1 stop bit each, baud_cnt=8 -> two pulses 80 clk apart. A third frame with baud_cnt=2 -> decoded at 4 clk/bit, one pulse.
REQ-032 rst_n asserted during data bit 4 of a frame, released 10 clk later -> no pulse; the next full 8'h96 frame -> one pulse.
